// File: rtl/ml_frame_loader_if.sv
// rtl/ml_frame_loader_if.sv - frame stream and detector-side signal bundle for ml_frame_loader
//
// Purpose: groups the word-serial input stream, the detector drive signals and the
// status outputs of ml_frame_loader into one interface.
// Signals:
//   in_valid/in_data/in_last/in_ready  word-serial frame stream (valid/ready)
//   enable/cnt                         detector enable and 6-bit hypothesis index
//   r/y_hat                            assembled 320-bit R and 160-bit y_hat buses
//   det_valid                          detector completion pulse (releases read buffer)
//   busy/err                           sequencer not idle / framing-error pulse
// Modports: master = upstream source and detector side, slave = the loader.
interface ml_frame_loader_if #(
    parameter int DATA_WIDTH = 20
);
    logic                      in_valid;
    logic [DATA_WIDTH-1:0]     in_data;
    logic                      in_last;
    logic                      in_ready;
    logic                      enable;
    logic [5:0]                cnt;
    logic [16*DATA_WIDTH-1:0]  r;
    logic [8*DATA_WIDTH-1:0]   y_hat;
    logic                      det_valid;
    logic                      busy;
    logic                      err;

    modport master (
        output in_valid, in_data, in_last, det_valid,
        input  in_ready, enable, cnt, r, y_hat, busy, err
    );

    modport slave (
        input  in_valid, in_data, in_last, det_valid,
        output in_ready, enable, cnt, r, y_hat, busy, err
    );
endinterface

// File: rtl/ml_frame_loader.sv
// rtl/ml_frame_loader.sv - frame staging buffer and 64-hypothesis sweep sequencer for the 4x4 QPSK ML detector
//
// Purpose: collects a 24-word frame (16 R words + 8 y_hat words) from a valid/ready
// stream, presents it on the detector's R / y_hat buses and steps the detector through
// all 64 symbol hypotheses, holding the buffer until the detector reports completion.
// Ports:
//   i_clk      rising-edge clock
//   i_reset_n  asynchronous active-low reset
//   bus        ml_frame_loader_if.slave (stream in, detector drive, status)
// Configuration: define ML_FRAME_LOADER_DBUF_EN for two frame buffers so loading of the
// next frame overlaps the sweep/wait of the current one; undefined gives one buffer.
module ml_frame_loader #(
    parameter int DATA_WIDTH  = 20,
    parameter int FRAME_WORDS = 24
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    ml_frame_loader_if.slave   bus
);

`ifdef ML_FRAME_LOADER_DBUF_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif
    localparam logic [4:0] LAST_WP = 5'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_WAIT} state_t;

    state_t                 state, state_d;
    logic [5:0]             cnt_q, cnt_d;
    logic                   enable;
    logic [DATA_WIDTH-1:0]  mem [NBUF][FRAME_WORDS];
    logic [NBUF-1:0]        full;
    logic                   wsel, rsel;
    logic [4:0]             wp;
    logic                   err_q;
    logic                   accept, frame_bad, frame_done, release_buf;

    // Ready depends only on buffer flags so the source may wait on it combinationally.
    assign bus.in_ready = ~full[wsel];
    assign accept       = bus.in_valid & bus.in_ready;
    // A frame is well-formed only when in_last coincides exactly with the final word.
    assign frame_bad    = accept & (bus.in_last != (wp == LAST_WP));
    assign frame_done   = accept & bus.in_last & (wp == LAST_WP);
    assign release_buf  = (state == S_WAIT) & bus.det_valid;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int b = 0; b < NBUF; b++) begin
                for (int k = 0; k < FRAME_WORDS; k++) begin
                    mem[b][k] <= '0;
                end
            end
            full  <= '0;
            wp    <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= frame_bad;
            if (accept) begin
                mem[wsel][wp] <= bus.in_data;
                wp <= (frame_bad || frame_done) ? 5'd0 : wp + 5'd1;
            end
            // Release and completion may land on the same edge; they always target
            // different buffers, so each flag is updated independently.
            for (int b = 0; b < NBUF; b++) begin
                if (release_buf && (rsel == 1'(b))) begin
                    full[b] <= 1'b0;
                end
                if (frame_done && (wsel == 1'(b))) begin
                    full[b] <= 1'b1;
                end
            end
        end
    end

`ifdef ML_FRAME_LOADER_DBUF_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wsel <= 1'b0;
            rsel <= 1'b0;
        end else begin
            if (frame_done) begin
                wsel <= ~wsel;
            end
            if (release_buf) begin
                rsel <= ~rsel;
            end
        end
    end
`else
    assign wsel = 1'b0;
    assign rsel = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
            cnt_q <= '0;
        end else begin
            state <= state_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = 6'd0;
        enable  = 1'b0;
        case (state)
            S_IDLE: begin
                if (full[rsel]) begin
                    state_d = S_SWEEP;
                end
            end
            S_SWEEP: begin
                enable = 1'b1;
                // Wraps to 0 after 63, which is the value WAIT must present.
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.det_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.enable = enable;
    assign bus.cnt    = cnt_q;
    assign bus.busy   = (state != S_IDLE);
    assign bus.err    = err_q;

    for (genvar k = 0; k < 16; k++) begin : g_r
        assign bus.r[k*DATA_WIDTH +: DATA_WIDTH] = mem[rsel][k];
    end

    for (genvar m = 0; m < 8; m++) begin : g_y
        assign bus.y_hat[m*DATA_WIDTH +: DATA_WIDTH] = mem[rsel][16+m];
    end

endmodule
